// File: rtl/vga_timing_ctrl.sv
// VGA raster timing on clk_50 using a derived 25 MHz pixel strobe.
// Requests each pixel one pixel ahead and registers the returned value onto the DAC outputs.
module vga_timing_ctrl #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter bit SYNC_POL = 1'b0
) (
    input  logic        clk_50,
    input  logic        reset_n,
    input  logic        enable,
    input  logic [11:0] px_data,
    output logic        pix_ce,
    output logic        px_req,
    output logic [9:0]  px_x,
    output logic [9:0]  px_y,
    output logic        hsync,
    output logic        vsync,
    output logic        active,
    output logic [11:0] rgb,
    output logic        frame_start
);
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    // 11-bit compare constants so a 1024-wide region end does not wrap
    localparam logic [9:0]  H_LAST = 10'(H_TOTAL - 1);
    localparam logic [9:0]  V_LAST = 10'(V_TOTAL - 1);
    localparam logic [10:0] H_VIS  = 11'(H_ACTIVE);
    localparam logic [10:0] V_VIS  = 11'(V_ACTIVE);
    localparam logic [10:0] HS_BEG = 11'(H_ACTIVE + H_FP);
    localparam logic [10:0] HS_END = 11'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [10:0] VS_BEG = 11'(V_ACTIVE + V_FP);
    localparam logic [10:0] VS_END = 11'(V_ACTIVE + V_FP + V_SYNC);

    logic       run;
    logic       h_wrap;
    logic       v_wrap;
    logic [9:0] h_nxt;
    logic [9:0] v_nxt;
    logic       vis_nxt;
    logic       hs_on;
    logic       vs_on;

    always_comb begin
        h_wrap  = (px_x == H_LAST);
        v_wrap  = (px_y == V_LAST);
        h_nxt   = h_wrap ? 10'd0 : px_x + 10'd1;
        v_nxt   = px_y;
        if (h_wrap) begin
            v_nxt = v_wrap ? 10'd0 : px_y + 10'd1;
        end
        vis_nxt = ({1'b0, h_nxt} < H_VIS) && ({1'b0, v_nxt} < V_VIS);
        hs_on   = ({1'b0, px_x} >= HS_BEG) && ({1'b0, px_x} < HS_END);
        vs_on   = ({1'b0, px_y} >= VS_BEG) && ({1'b0, px_y} < VS_END);
    end

    always_ff @(posedge clk_50) begin
        if (!reset_n) begin
            pix_ce      <= 1'b0;
            run         <= 1'b0;
            px_x        <= 10'd0;
            px_y        <= 10'd0;
            px_req      <= 1'b0;
            hsync       <= ~SYNC_POL;
            vsync       <= ~SYNC_POL;
            active      <= 1'b0;
            rgb         <= 12'd0;
            frame_start <= 1'b0;
        end else begin
            pix_ce      <= ~pix_ce;
            frame_start <= 1'b0;
            if (pix_ce) begin
                run <= enable;
                if (!run) begin
                    // parked: (0,0) is always visible, so the request follows enable
                    px_x   <= 10'd0;
                    px_y   <= 10'd0;
                    px_req <= enable;
                    hsync  <= ~SYNC_POL;
                    vsync  <= ~SYNC_POL;
                    active <= 1'b0;
                    rgb    <= 12'd0;
                end else begin
                    px_x        <= h_nxt;
                    px_y        <= v_nxt;
                    px_req      <= enable & vis_nxt;
                    frame_start <= h_wrap & v_wrap;
                    active      <= px_req;
                    rgb         <= px_req ? px_data : 12'd0;
                    hsync       <= hs_on ? SYNC_POL : ~SYNC_POL;
                    vsync       <= vs_on ? SYNC_POL : ~SYNC_POL;
                end
            end
        end
    end
endmodule
